// File: rtl/gshare_pkg.sv
// Shared constants, types and counter-update helper for the gshare PHT update path.
package gshare_pkg;

    localparam int unsigned DEPTH   = 64;
    localparam int unsigned INDEX   = 6;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned QDEPTH  = 4;
    localparam int unsigned QCNT_W  = $clog2(QDEPTH) + 1;

    localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(2);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [INDEX-1:0] idx;
        logic             taken;
    } upd_entry_t;

    // 2-bit (CNT_W) saturating counter step toward the resolved direction.
    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] old,
                                                    input logic             taken);
        if (taken && (old != {CNT_W{1'b1}}))
            return old + CNT_W'(1);
        if (!taken && (old != '0))
            return old - CNT_W'(1);
        return old;
    endfunction

endpackage

// File: rtl/gshare_upd_fifo.sv
// Circular update queue; head entry is visible combinationally, no push-to-pop bypass.
module gshare_upd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full_c    = (count == (PW+1)'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_push   = push && !full_c;
    assign do_pop    = pop && !empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage needs no reset; occupancy and pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + (PW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/gshare_pht_updater.sv
// Gshare PHT update controller: post-reset table sweep, then queued read-modify-write of 2-bit counters.
module gshare_pht_updater
    import gshare_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              upd_valid_i,
    output logic              upd_ready_o,
    input  logic [INDEX-1:0]  upd_pc_i,
    input  logic [INDEX-1:0]  upd_ghr_i,
    input  logic              upd_taken_i,
    input  logic              hold_i,
    output logic [INDEX-1:0]  rd_addr_o,
    input  logic [CNT_W-1:0]  rd_data_i,
    output logic [INDEX-1:0]  wr_addr_o,
    output logic [CNT_W-1:0]  wr_data_o,
    output logic              we_o,
    output logic              init_done_o,
    output logic [QCNT_W-1:0] count_o
);

    state_t             state;
    state_t             state_nxt;
    logic [INDEX-1:0]   sweep_ptr;
    logic [INDEX-1:0]   sweep_nxt;
    logic               we_nxt;
    logic [INDEX-1:0]   wr_addr_nxt;
    logic [CNT_W-1:0]   wr_data_nxt;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    upd_entry_t         in_entry;
    upd_entry_t         head;
    logic [CNT_W-1:0]   old_cnt;
    logic [CNT_W-1:0]   new_cnt;

    assign in_entry    = '{idx: upd_pc_i ^ upd_ghr_i, taken: upd_taken_i};
    assign upd_ready_o = (state == RUN) && !full;
    assign push        = upd_valid_i && upd_ready_o;
    assign init_done_o = (state == RUN);
    assign rd_addr_o   = head.idx;

    gshare_upd_fifo #(
        .DEPTH (QDEPTH),
        .W     ($bits(upd_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .wr_data   (in_entry),
        .pop       (pop),
        .rd_data_c (head),
        .full_c    (full),
        .empty_c   (empty),
        .count     (count_o)
    );

    // In-flight write has not reached the RAM yet, so it overrides the read port.
    always_comb begin
        old_cnt   = rd_data_i;
        if (we_o && (wr_addr_o == head.idx))
            old_cnt = wr_data_o;
        new_cnt   = sat_update(old_cnt, head.taken);
    end

    always_comb begin
        state_nxt   = state;
        sweep_nxt   = sweep_ptr;
        we_nxt      = 1'b0;
        wr_addr_nxt = wr_addr_o;
        wr_data_nxt = wr_data_o;
        pop         = 1'b0;
        if (state == INIT) begin
            we_nxt      = 1'b1;
            wr_addr_nxt = sweep_ptr;
            wr_data_nxt = INIT_VAL;
            sweep_nxt   = sweep_ptr + INDEX'(1);
            if (sweep_ptr == INDEX'(DEPTH - 1))
                state_nxt = RUN;
        end else if (!empty && !hold_i) begin
            pop = 1'b1;
            if (new_cnt != old_cnt) begin
                we_nxt      = 1'b1;
                wr_addr_nxt = head.idx;
                wr_data_nxt = new_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            sweep_ptr <= '0;
            we_o      <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            state     <= state_nxt;
            sweep_ptr <= sweep_nxt;
            we_o      <= we_nxt;
            wr_addr_o <= wr_addr_nxt;
            wr_data_o <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_gshare_pht_updater.sv
// Self-checking bench: ideal-table queue model plus directed literal checks and random traffic.
module tb_gshare_pht_updater;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       upd_valid_i;
    logic       upd_ready_o;
    logic [5:0] upd_pc_i;
    logic [5:0] upd_ghr_i;
    logic       upd_taken_i;
    logic       hold_i;
    logic [5:0] rd_addr_o;
    logic [1:0] rd_data_i;
    logic [5:0] wr_addr_o;
    logic [1:0] wr_data_o;
    logic       we_o;
    logic       init_done_o;
    logic [2:0] count_o;

    logic [1:0] ram [64];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        bit tk;
    } ent_t;

    ent_t m_q[$];
    int   m_pht[64];
    bit   m_run;
    int   m_sweep;
    bit   e_we;
    int   e_wa;
    int   e_wd;

    always #5 clk = ~clk;

    // PHT RAM stand-in: combinational read, write lands on the clock edge.
    assign rd_data_i = ram[rd_addr_o];
    always @(posedge clk) begin
        if (we_o)
            ram[wr_addr_o] <= wr_data_o;
    end

    gshare_pht_updater dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .upd_valid_i (upd_valid_i),
        .upd_ready_o (upd_ready_o),
        .upd_pc_i    (upd_pc_i),
        .upd_ghr_i   (upd_ghr_i),
        .upd_taken_i (upd_taken_i),
        .hold_i      (hold_i),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .we_o        (we_o),
        .init_done_o (init_done_o),
        .count_o     (count_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_run   = 1'b0;
        m_sweep = 0;
        e_we    = 1'b0;
        e_wa    = 0;
        e_wd    = 0;
    endtask

    // One clock edge of the reference: ideal table updated immediately, queue in arrival order.
    task automatic model_step();
        bit   rdy;
        bit   psh;
        ent_t e;
        int   o;
        int   n;
        rdy = m_run && (m_q.size() < 4);
        psh = upd_valid_i && rdy;
        if (!m_run) begin
            e_we = 1'b1;
            e_wa = m_sweep;
            e_wd = 2;
            m_pht[m_sweep] = 2;
            m_sweep++;
            if (m_sweep == 64)
                m_run = 1'b1;
        end else begin
            e_we = 1'b0;
            if (m_q.size() > 0 && !hold_i) begin
                e = m_q.pop_front();
                o = m_pht[e.idx];
                if (e.tk) n = (o < 3) ? o + 1 : 3;
                else      n = (o > 0) ? o - 1 : 0;
                m_pht[e.idx] = n;
                if (n != o) begin
                    e_we = 1'b1;
                    e_wa = e.idx;
                    e_wd = n;
                end
            end
        end
        if (psh) begin
            e.idx = int'(upd_pc_i ^ upd_ghr_i);
            e.tk  = upd_taken_i;
            m_q.push_back(e);
        end
    endtask

    task automatic check_all();
        chk("we", int'(we_o), int'(e_we));
        if (e_we) begin
            chk("wr_addr", int'(wr_addr_o), e_wa);
            chk("wr_data", int'(wr_data_o), e_wd);
        end
        chk("count", int'(count_o), m_q.size());
        chk("ready", int'(upd_ready_o), int'(m_run && (m_q.size() < 4)));
        chk("init_done", int'(init_done_o), int'(m_run));
        if (m_q.size() > 0)
            chk("rd_addr", int'(rd_addr_o), m_q[0].idx);
    endtask

    task automatic cycle(input bit v, input int pc, input int ghr, input bit tk, input bit hd);
        upd_valid_i = v;
        upd_pc_i    = 6'(pc);
        upd_ghr_i   = 6'(ghr);
        upd_taken_i = tk;
        hold_i      = hd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic sweep_phase(input string tag);
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b1, 1'b0);
            if (i == 0) begin
                chk({tag, "_first_addr"}, int'(wr_addr_o), 0);
                chk({tag, "_first_data"}, int'(wr_data_o), 2);
            end
            if (i == 62)
                chk({tag, "_done_early"}, int'(init_done_o), 0);
        end
        chk({tag, "_last_addr"}, int'(wr_addr_o), 63);
        chk({tag, "_done"}, int'(init_done_o), 1);
        chk({tag, "_ready"}, int'(upd_ready_o), 1);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        upd_valid_i = 1'b0;
        upd_pc_i    = '0;
        upd_ghr_i   = '0;
        upd_taken_i = 1'b0;
        hold_i      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_we", int'(we_o), 0);
        chk("rst_wr_addr", int'(wr_addr_o), 0);
        chk("rst_wr_data", int'(wr_data_o), 0);
        chk("rst_ready", int'(upd_ready_o), 0);
        chk("rst_done", int'(init_done_o), 0);
        chk("rst_count", int'(count_o), 0);
        reset_n = 1'b1;
        sweep_phase("sweep1");

        // Basic RMW: idx 5^3 = 6, counter 2 -> 3
        cycle(1'b1, 5, 3, 1'b1, 1'b0);
        chk("basic_rd_addr", int'(rd_addr_o), 6);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk("basic_we", int'(we_o), 1);
        chk("basic_wr_addr", int'(wr_addr_o), 6);
        chk("basic_wr_data", int'(wr_data_o), 3);

        // Saturate 0x10 high, then one more taken must not write
        cycle(1'b1, 16, 0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 16, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk("sat_hi_we", int'(we_o), 0);
        chk("sat_hi_count", int'(count_o), 0);

        // Saturate 0x11 low, then one more not-taken must not write
        cycle(1'b1, 17, 0, 1'b0, 1'b0);
        cycle(1'b1, 17, 0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 17, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk("sat_lo_we", int'(we_o), 0);
        chk("sat_lo_count", int'(count_o), 0);

        // Forwarding: 0x20 brought to 1, then two back-to-back taken -> 2 then 3
        cycle(1'b1, 32, 0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 32, 0, 1'b1, 1'b0);
        cycle(1'b1, 32, 0, 1'b1, 1'b0);
        chk("fwd_wr_data1", int'(wr_data_o), 2);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk("fwd_we2", int'(we_o), 1);
        chk("fwd_wr_data2", int'(wr_data_o), 3);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);

        // Backpressure: hold with 5 offers -> 4 accepted
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 48 + i, 0, 1'b1, 1'b1);
        chk("bp_count", int'(count_o), 4);
        chk("bp_ready", int'(upd_ready_o), 0);
        cycle(1'b1, 52, 0, 1'b1, 1'b0);
        chk("bp_pop_count", int'(count_o), 3);
        chk("bp_pop_ready", int'(upd_ready_o), 1);
        cycle(1'b1, 52, 0, 1'b1, 1'b0);
        chk("bp_fifth_count", int'(count_o), 3);
        repeat (5) cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk("bp_drained", int'(count_o), 0);

        // Reset mid-drain with three queued
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 56 + i, 0, 1'b1, 1'b1);
        cycle(1'b1, 59, 0, 1'b1, 1'b0);
        chk("mid_count", int'(count_o), 3);
        chk("mid_we", int'(we_o), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_we", int'(we_o), 0);
        chk("async_count", int'(count_o), 0);
        chk("async_done", int'(init_done_o), 0);
        model_reset();
        @(negedge clk);
        upd_valid_i = 1'b0;
        reset_n = 1'b1;
        sweep_phase("sweep2");

        // Random traffic over a small index set to provoke collisions and saturation
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(0, 63)),
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 4) == 0);
        end
        repeat (6) cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk("final_count", int'(count_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
